alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//   Parametrised multi-cycle ALU with valid/ready handshakes on operand and result sides.
//   Single-cycle logic/arith ops plus iterative unsigned multiply/divide.
//   Registered result with zero/carry/overflow flags.
//   Sits between decode/register-read and writeback; the execute stage stalls on in_ready.
// PARAMETERS
//   WIDTH  64  operand/result width in bits (>=8)
//   CNTW   $clog2(WIDTH)+1  iteration counter width (derived, do not override)
// PORTS
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous, active-high reset
//   in_valid    in   1      operands/op valid
//   in_ready    out  1      block accepts operands this cycle
//   data1       in   WIDTH  operand A
//   data2       in   WIDTH  operand B
//   ALU_Select  in   4      opcode
//   out_valid   out  1      result/flags valid
//   out_ready   in   1      consumer takes result this cycle
//   result      out  WIDTH  registered result
//   zero        out  1      result == 0
//   carry       out  1      ADD: carry out; SUB: 1 = no borrow; else 0
//   ovf         out  1      signed overflow (ADD/SUB only), else 0
//   illegal     out  1      opcode not in table; result forced to 0
// BEHAVIOUR
//   Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 PASS data2, 1100 NOR,
//     1000 MULLO (low WIDTH bits of unsigned product), 1001 DIVU quotient, 1010 REMU.
//   Accept = in_valid && in_ready; operands and opcode are latched on accept.
//   FSM IDLE -> (accept, 1-cycle op) DONE | (accept, MUL/DIV) BUSY -> after WIDTH cycles -> DONE.
//   DONE: out_valid=1; result/flags held stable until out_ready.
//     DONE && out_ready && !in_valid -> IDLE.
//     DONE && out_ready && in_valid -> new accept, same rules as from IDLE.
//   in_ready = (state==IDLE) || (state==DONE && out_ready); 0 in BUSY.
//   Latency accept->out_valid: 1 cycle single-cycle ops; WIDTH+1 cycles MUL/DIV.
//   Back-to-back single-cycle ops with out_ready held at 1 sustain one result per cycle.
//   MULLO: shift-add, one multiplier bit per cycle, LSB first; upper product bits discarded.
//   DIVU/REMU: restoring, one quotient bit per cycle, MSB first.
//   Divide by zero: quotient = all ones; remainder = data1; illegal = 0; still WIDTH cycles.
//   Flags are computed from the final result and registered with it; zero is valid for every op.
//   Illegal opcode: 1-cycle path; result = 0, zero = 1, illegal = 1.
//   out_ready while out_valid=0 is ignored; in_valid while in_ready=0 is ignored (no capture).
//   Reset (any state, incl. mid-BUSY): state=IDLE; in-flight op dropped.
//     After reset: out_valid=0, result=0, zero=0, carry=0, ovf=0, illegal=0, counter=0.
//     in_ready=1 from the first clock after rst deasserts.
// CONFIGURATION
//   ALU_MULDIV_EN defined: opcodes 1000/1001/1010 and BUSY state are implemented as above.
//   ALU_MULDIV_EN undefined: those opcodes are illegal (1-cycle, result 0, illegal=1).
//     BUSY state, counter and shift datapath are not synthesised; in_ready = IDLE || (DONE && out_ready).
// TESTING
//   1. ADD 0x7FFF_FFFF_FFFF_FFFF + 1, out_ready=1 -> 1 cycle later result=0x8000_0000_0000_0000, ovf=1, carry=0, zero=0.
//   2. SUB 5 - 5 -> result=0, zero=1, carry=1; SUB 3 - 5 -> result=0xFFFF_FFFF_FFFF_FFFE, carry=0, ovf=0.
//   3. MULLO 0x1_0000_0003 * 7 -> in_ready=0 for 64 cycles; out_valid on cycle 65; result=0x7_0000_0015.
//   4. DIVU 100/7 -> result=14; REMU 100/7 -> result=2; DIVU 9/0 -> all ones; REMU 9/0 -> 9.
//   5. Hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0; then out_ready=1 with
//      in_valid=1 (AND 0xF0 & 0x3C) -> accepted same cycle; next cycle result=0x30.
//   6. Assert rst on cycle 20 of a DIVU -> out_valid=0 and flags 0 immediately;
//      OR 1|2 issued after release -> result=3 with 1-cycle latency.
//   7. Opcode 0011 -> illegal=1, result=0, zero=1; without ALU_MULDIV_EN, opcode 1000 -> illegal=1 after 1 cycle.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: valid/ready ALU with 1-cycle logic/arith ops; ALU_MULDIV_EN adds iterative MULLO/DIVU/REMU
module alu_mc #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [3:0]       ALU_Select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             illegal
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, s_res;
  logic zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, illegal_q, illegal_d;
  logic s_carry, s_ovf, s_ill, accept, is_md;
  logic [WIDTH:0] sum, dif;
  assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = state_q == DONE;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign illegal   = illegal_q;
  // single-cycle datapath evaluated on the live operands, captured on accept
  always_comb begin
    sum = {1'b0, data1} + {1'b0, data2};
    dif = {1'b0, data1} - {1'b0, data2};
    s_res = ALU_Select == 4'b0000 ? data1 & data2 :
            ALU_Select == 4'b0001 ? data1 | data2 :
            ALU_Select == 4'b0010 ? sum[WIDTH-1:0] :
            ALU_Select == 4'b0110 ? dif[WIDTH-1:0] :
            ALU_Select == 4'b0111 ? data2 :
            ALU_Select == 4'b1100 ? ~(data1 | data2) : '0;
    s_ill = !(ALU_Select inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100});
    s_carry = ALU_Select == 4'b0010 ? sum[WIDTH] : ALU_Select == 4'b0110 ? !dif[WIDTH] : 1'b0;
    s_ovf = ALU_Select == 4'b0010 ? (data1[WIDTH-1] == data2[WIDTH-1]) && (sum[WIDTH-1] != data1[WIDTH-1]) :
            ALU_Select == 4'b0110 ? (data1[WIDTH-1] != data2[WIDTH-1]) && (dif[WIDTH-1] != data1[WIDTH-1]) : 1'b0;
  end
`ifdef ALU_MULDIV_EN
  localparam int CNTW = $clog2(WIDTH) + 1;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, mul_n, quo_n, rem_n, md_res;
  logic [WIDTH:0] part;
  logic [1:0] op_q, op_d;
  logic busy, ge, last;
  assign is_md = ALU_Select inside {4'b1000, 4'b1001, 4'b1010};
  // one shift-add (a<<, b>> , acc+=) or restoring-divide (a=quotient, acc=remainder) step per cycle
  always_comb begin
    busy = state_q == BUSY;
    last = busy && cnt_q == CNTW'(WIDTH - 1);
    mul_n = acc_q + (b_q[0] ? a_q : '0);
    part = {acc_q, a_q[WIDTH-1]};
    ge = part >= {1'b0, b_q};
    quo_n = {a_q[WIDTH-2:0], ge};
    rem_n = ge ? part[WIDTH-1:0] - b_q : part[WIDTH-1:0];
    md_res = op_q == 2'b00 ? mul_n : op_q == 2'b01 ? quo_n : rem_n;
    cnt_d = busy && !last ? cnt_q + 1'b1 : '0;
    op_d = accept ? ALU_Select[1:0] : op_q;
    a_d = accept ? data1 : busy ? (op_q == 2'b00 ? a_q << 1 : quo_n) : a_q;
    b_d = accept ? data2 : busy && op_q == 2'b00 ? b_q >> 1 : b_q;
    acc_d = accept ? '0 : busy ? (op_q == 2'b00 ? mul_n : rem_n) : acc_q;
  end
`else
  assign is_md = 1'b0;
`endif
  // control FSM next state and result/flag capture
  always_comb begin
    state_d = state_q;
    result_d = result_q;
    zero_d = zero_q;
    carry_d = carry_q;
    ovf_d = ovf_q;
    illegal_d = illegal_q;
    if (state_q == DONE && out_ready) state_d = IDLE;
    if (accept && is_md) state_d = BUSY;
    else if (accept) begin
      state_d = DONE;
      result_d = s_res;
      zero_d = s_res == '0;
      carry_d = s_carry;
      ovf_d = s_ovf;
      illegal_d = s_ill;
    end
`ifdef ALU_MULDIV_EN
    if (last) begin
      state_d = DONE;
      result_d = md_res;
      zero_d = md_res == '0;
      carry_d = 1'b0;
      ovf_d = 1'b0;
      illegal_d = 1'b0;
    end
`endif
  end
  // state and registered outputs; reset drops any in-flight op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      result_q <= '0;
      zero_q <= 1'b0;
      carry_q <= 1'b0;
      ovf_q <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_MULDIV_EN
      cnt_q <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      result_q <= result_d;
      zero_q <= zero_d;
      carry_q <= carry_d;
      ovf_q <= ovf_d;
      illegal_q <= illegal_d;
`ifdef ALU_MULDIV_EN
      cnt_q <= cnt_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc (WIDTH=64)
module tb_alu_mc;
  logic clk, rst, in_valid, in_ready, out_valid, out_ready, zero, carry, ovf, illegal;
  logic [63:0] data1, data2, result;
  logic [3:0] ALU_Select;
  int checks = 0, passed = 0;
  typedef struct packed {logic [3:0] op; logic [63:0] a, b, r; logic [3:0] f;} vec_t;
  vec_t v[10];
  alu_mc #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data1(data1), .data2(data2), .ALU_Select(ALU_Select),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .carry(carry), .ovf(ovf), .illegal(illegal)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    in_valid = 1'b1;
    ALU_Select = op;
    data1 = a;
    data2 = b;
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    ALU_Select = '0;
    data1 = '0;
    data2 = '0;
    tick;
    tick;
    checks++;
    if ({out_valid, result, zero, carry, ovf, illegal} !== '0)
      $display("FAIL reset_state: got v=%b r=%h f=%b%b%b%b required all 0", out_valid, result, zero, carry, ovf, illegal);
    else passed++;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready);
    else passed++;
    tick;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL post_reset_idle: got v=%b rdy=%b required 0/1", out_valid, in_ready);
    else passed++;
  endtask
  task automatic test_single_ops;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(v[i].op, v[i].a, v[i].b);
      checks++;
      if (in_ready !== 1'b1) $display("FAIL single[%0d]_ready: got %b required 1", i, in_ready);
      else passed++;
      tick;
      in_valid = 1'b0;
      checks++;
      if ({out_valid, result, zero, carry, ovf, illegal} !== {1'b1, v[i].r, v[i].f})
        $display("FAIL single[%0d]: got v=%b r=%h f=%b%b%b%b required v=1 r=%h f=%b", i, out_valid, result, zero, carry, ovf, illegal, v[i].r, v[i].f);
      else passed++;
      tick;
      checks++;
      if (out_valid !== 1'b0) $display("FAIL single[%0d]_drain: got v=%b required 0", i, out_valid);
      else passed++;
    end
  endtask
  task automatic test_back_to_back;
    out_ready = 1'b1;
    drive(v[0].op, v[0].a, v[0].b);
    tick;
    for (int i = 1; i <= 10; i++) begin
      checks++;
      if ({out_valid, result, zero, carry, ovf, illegal} !== {1'b1, v[i-1].r, v[i-1].f})
        $display("FAIL b2b[%0d]: got v=%b r=%h f=%b%b%b%b required v=1 r=%h f=%b", i - 1, out_valid, result, zero, carry, ovf, illegal, v[i-1].r, v[i-1].f);
      else passed++;
      if (i < 10) begin
        drive(v[i].op, v[i].a, v[i].b);
        checks++;
        if (in_ready !== 1'b1) $display("FAIL b2b[%0d]_ready: got %b required 1", i, in_ready);
        else passed++;
        tick;
      end
    end
    in_valid = 1'b0;
    tick;
  endtask
  task automatic test_hold;
    out_ready = 1'b0;
    drive(4'b0001, 64'd1, 64'd2);
    tick;
    drive(4'b0000, 64'hF0, 64'h3C);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || result !== 64'd3 || in_ready !== 1'b0)
        $display("FAIL hold[%0d]: got v=%b r=%h rdy=%b required 1/3/0", i, out_valid, result, in_ready);
      else passed++;
      tick;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL hold_release_ready: got %b required 1", in_ready);
    else passed++;
    tick;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 64'h30 || zero !== 1'b0)
      $display("FAIL hold_next: got v=%b r=%h z=%b required 1/30/0", out_valid, result, zero);
    else passed++;
    tick;
  endtask
  task automatic test_illegal;
    logic [3:0] ill[$];
    ill = {4'b0011, 4'b1111, 4'b0100};
`ifndef ALU_MULDIV_EN
    ill.push_back(4'b1000);
    ill.push_back(4'b1001);
    ill.push_back(4'b1010);
`endif
    out_ready = 1'b1;
    foreach (ill[i]) begin
      drive(ill[i], 64'h55, 64'h66);
      tick;
      in_valid = 1'b0;
      checks++;
      if ({out_valid, result, zero, carry, ovf, illegal} !== {1'b1, 64'd0, 4'b1001})
        $display("FAIL illegal_%b: got v=%b r=%h f=%b%b%b%b required v=1 r=0 f=1001", ill[i], out_valid, result, zero, carry, ovf, illegal);
      else passed++;
      tick;
    end
  endtask
`ifdef ALU_MULDIV_EN
  task automatic test_muldiv;
    vec_t m[5];
    int bad;
    m[0] = '{4'b1000, 64'h1_0000_0003, 64'd7, 64'h7_0000_0015, 4'b0000};
    m[1] = '{4'b1001, 64'd100, 64'd7, 64'd14, 4'b0000};
    m[2] = '{4'b1010, 64'd100, 64'd7, 64'd2, 4'b0000};
    m[3] = '{4'b1001, 64'd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000};
    m[4] = '{4'b1010, 64'd9, 64'd0, 64'd9, 4'b0000};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(m[i].op, m[i].a, m[i].b);
      tick;
      drive(4'b0010, 64'd1, 64'd1);
      bad = 0;
      for (int c = 0; c < 64; c++) begin
        if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
        tick;
      end
      checks++;
      if (bad != 0) $display("FAIL md[%0d]_busy: got %0d non-busy cycles required 0", i, bad);
      else passed++;
      checks++;
      if ({out_valid, result, zero, carry, ovf, illegal} !== {1'b1, m[i].r, m[i].f})
        $display("FAIL md[%0d]: got v=%b r=%h f=%b%b%b%b required v=1 r=%h f=%b", i, out_valid, result, zero, carry, ovf, illegal, m[i].r, m[i].f);
      else passed++;
      in_valid = 1'b0;
      tick;
    end
  endtask
`endif
  task automatic test_reset_mid;
    out_ready = 1'b1;
    drive(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    tick;
    in_valid = 1'b0;
    checks++;
    if ({zero, carry} !== 2'b11) $display("FAIL pre_reset_flags: got z=%b c=%b required 1/1", zero, carry);
    else passed++;
`ifdef ALU_MULDIV_EN
    drive(4'b1001, 64'd100, 64'd7);
    tick;
    in_valid = 1'b0;
    repeat (19) tick;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL mid_div_busy: got rdy=%b required 0", in_ready);
    else passed++;
`else
    out_ready = 1'b0;
    drive(4'b0001, 64'd1, 64'd2);
    tick;
    in_valid = 1'b0;
    tick;
    checks++;
    if (out_valid !== 1'b1) $display("FAIL pre_reset_done: got v=%b required 1", out_valid);
    else passed++;
`endif
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, result, zero, carry, ovf, illegal} !== '0)
      $display("FAIL async_reset: got v=%b r=%h f=%b%b%b%b required all 0", out_valid, result, zero, carry, ovf, illegal);
    else passed++;
    tick;
    rst = 1'b0;
    out_ready = 1'b1;
    drive(4'b0001, 64'd1, 64'd2);
    checks++;
    if (in_ready !== 1'b1) $display("FAIL after_reset_ready: got %b required 1", in_ready);
    else passed++;
    tick;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 64'd3)
      $display("FAIL after_reset_or: got v=%b r=%h required 1/3", out_valid, result);
    else passed++;
    tick;
  endtask
  initial begin
    v[0] = '{4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b0010};
    v[1] = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b1100};
    v[2] = '{4'b0110, 64'd5, 64'd5, 64'd0, 4'b1100};
    v[3] = '{4'b0110, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0000};
    v[4] = '{4'b0110, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0110};
    v[5] = '{4'b0000, 64'hF0, 64'h3C, 64'h30, 4'b0000};
    v[6] = '{4'b0001, 64'd1, 64'd2, 64'd3, 4'b0000};
    v[7] = '{4'b1100, 64'h00FF, 64'hFF00, 64'hFFFF_FFFF_FFFF_0000, 4'b0000};
    v[8] = '{4'b0111, 64'd5, 64'h1234, 64'h1234, 4'b0000};
    v[9] = '{4'b0011, 64'd5, 64'd6, 64'd0, 4'b1001};
    test_reset;
    test_single_ops;
    test_back_to_back;
    test_hold;
    test_illegal;
`ifdef ALU_MULDIV_EN
    test_muldiv;
`endif
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
